// File: rtl/ahbl_apb_pkg.sv
// Shared encodings for the AHB-Lite to APB3 bridge: FSM states, HTRANS and HRESP codes.
package ahbl_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_t;

  // Slave index is the 4 address bits just above the per-slave window.
  localparam int IDX_W = 4;

endpackage

// File: rtl/apb_slave_mux.sv
// Return-path mux: picks PRDATA/PREADY/PSLVERR of the slave addressed by idx.
module apb_slave_mux
  import ahbl_apb_pkg::*;
#(
  parameter int NSLV = 4
) (
  input  logic [IDX_W-1:0]   idx,
  input  logic [32*NSLV-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr,
  output logic [31:0]        sel_rdata,
  output logic               sel_ready,
  output logic               sel_slverr
);

  logic [NSLV-1:0] hit;

  for (genvar i = 0; i < NSLV; i++) begin : g_hit
    assign hit[i] = (idx == IDX_W'(i));
  end

  // AND-OR mux; an out-of-range idx selects nothing and reads as not-ready.
  always_comb begin
    sel_rdata  = '0;
    sel_ready  = 1'b0;
    sel_slverr = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      sel_rdata  = sel_rdata | (prdata[32*i +: 32] & {32{hit[i]}});
      sel_ready  = sel_ready | (pready[i] & hit[i]);
      sel_slverr = sel_slverr | (pslverr[i] & hit[i]);
    end
  end

endmodule

// File: rtl/ahbl_apb_bridge.sv
// AHB-Lite slave that runs each single transfer as an APB3 access to one of NSLV slaves.
// Optional ACCESS-phase timeout compiled in with `define AHBL_APB_TIMEOUT_EN.
module ahbl_apb_bridge
  import ahbl_apb_pkg::*;
#(
  parameter int NSLV        = 4,
  parameter int PADDR_W     = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSEL,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [31:0]          HWDATA,
  input  logic                 HREADY,
  output logic                 HREADYOUT,
  output logic [31:0]          HRDATA,
  output logic                 HRESP,
  output logic [PADDR_W-1:0]   PADDR,
  output logic [NSLV-1:0]      PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PWDATA,
  input  logic [32*NSLV-1:0]   PRDATA,
  input  logic [NSLV-1:0]      PREADY,
  input  logic [NSLV-1:0]      PSLVERR
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic              accept, can_accept, idx_bad, to_hit;
  logic [31:0]       sel_rdata;
  logic              sel_ready, sel_slverr;
  logic [NSLV-1:0]   psel_hot;
  logic              unused_ahb;

  assign accept     = HSEL & HTRANS[1] & HREADY;
  assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign idx_bad    = ({1'b0, idx_q} >= (IDX_W+1)'(NSLV));
  assign psel_hot   = NSLV'(1) << idx_q;
  assign unused_ahb = ^{HADDR[31:PADDR_W+IDX_W], HTRANS[0]};

  apb_slave_mux #(.NSLV(NSLV)) u_mux (
    .idx       (idx_q),
    .prdata    (PRDATA),
    .pready    (PREADY),
    .pslverr   (PSLVERR),
    .sel_rdata (sel_rdata),
    .sel_ready (sel_ready),
    .sel_slverr(sel_slverr)
  );

`ifdef AHBL_APB_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC+1) < 8) ? 8 : $clog2(TIMEOUT_CYC+1);
  logic [TO_W-1:0] to_cnt;

  // Counts completed ACCESS cycles; hit flags the last allowed one.
  always_ff @(posedge HCLK) begin
    if (HRESET || state_q != ST_ACCESS) to_cnt <= '0;
    else                                to_cnt <= to_cnt + TO_W'(1);
  end
  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYC-1));
`else
  logic [31:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    PSEL      = '0;
    PENABLE   = 1'b0;
    case (state_q)
      ST_IDLE:    if (accept) state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        HREADYOUT = 1'b0;
        state_d   = idx_bad ? ST_ERR1 : ST_SETUP;
      end
      ST_SETUP: begin
        HREADYOUT = 1'b0;
        PSEL      = psel_hot;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        HREADYOUT = 1'b0;
        PSEL      = psel_hot;
        PENABLE   = 1'b1;
        if (sel_ready)   state_d = sel_slverr ? ST_ERR1 : ST_DONE;
        else if (to_hit) state_d = ST_ERR1;
      end
      ST_DONE:    state_d = accept ? ST_CAPTURE : ST_IDLE;
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP   = HRESP_ERROR;
        state_d = accept ? ST_CAPTURE : ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

  // Address/control are only reloaded between transfers, so they stay put through SETUP/ACCESS.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      idx_q  <= '0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      HRDATA <= '0;
    end else begin
      if (accept && can_accept) begin
        idx_q  <= HADDR[PADDR_W +: IDX_W];
        PADDR  <= HADDR[PADDR_W-1:0];
        PWRITE <= HWRITE;
      end
      if (state_q == ST_CAPTURE && PWRITE) PWDATA <= HWDATA;
      if (state_q == ST_ACCESS && sel_ready && !sel_slverr && !PWRITE) HRDATA <= sel_rdata;
    end
  end

endmodule

// File: tb/tb_ahbl_apb_bridge.sv
// Directed bench for ahbl_apb_bridge with AHB and APB scoreboards fed by the stimulus process.
module tb_ahbl_apb_bridge;
  localparam int NSLV = 4;
  localparam int PADDR_W = 16;

  logic                HCLK = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0;
  logic [31:0]         HADDR = '0, HWDATA = '0;
  logic [1:0]          HTRANS = 2'b00;
  logic                HREADY, HREADYOUT, HRESP, PENABLE, PWRITE;
  logic [31:0]         HRDATA, PWDATA;
  logic [PADDR_W-1:0]  PADDR;
  logic [NSLV-1:0]     PSEL, PREADY, PSLVERR;
  logic [32*NSLV-1:0]  PRDATA = '0;
  logic [NSLV-1:0]     err_mask = '0;
  int ready_delay = 0, acc_cnt = 0, cyc = 0, setups = 0;
  int n_chk = 0, n_pass = 0;

  typedef struct { logic err; logic rd; logic [31:0] rdata; int waits; } ahb_exp_t;
  typedef struct { logic [NSLV-1:0] psel; logic [PADDR_W-1:0] paddr; logic pwrite; logic [31:0] pwdata; } apb_exp_t;
  ahb_exp_t ahb_q[$];
  apb_exp_t apb_q[$];

  always #5 HCLK = ~HCLK;
  assign HREADY  = HREADYOUT;
  assign PREADY  = (acc_cnt >= ready_delay) ? {NSLV{1'b1}} : {NSLV{1'b0}};
  assign PSLVERR = err_mask;

  always @(posedge HCLK) begin
    cyc     <= cyc + 1;
    acc_cnt <= (|PSEL && PENABLE) ? acc_cnt + 1 : 0;
  end

  ahbl_apb_bridge #(.NSLV(NSLV), .PADDR_W(PADDR_W), .TIMEOUT_CYC(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  function automatic void fail(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) fail(nm, act, exp);
    else begin n_chk++; n_pass++; end
  endfunction

  // AHB monitor: counts wait states of each data phase and scores the response.
  logic pend = 1'b0, prev_resp = 1'b0;
  int   waits = 0;
  always @(negedge HCLK) begin
    ahb_exp_t e;
    if (HRESET) pend = 1'b0;
    else begin
      if (pend) begin
        if (!HREADYOUT) begin
          prev_resp = HRESP;
          waits++;
          if (waits > 150) begin fail("ahb_data_phase_timeout", waits, 150); pend = 1'b0; end
        end else begin
          pend = 1'b0;
          if (ahb_q.size() == 0) fail("ahb_unexpected_response", waits, 0);
          else begin
            e = ahb_q.pop_front();
            chk("hresp", HRESP, e.err);
            chk("wait_states", waits, e.waits);
            if (e.err) chk("err1_hresp", prev_resp, 1'b1);
            else if (e.rd) chk("hrdata", HRDATA, e.rdata);
          end
        end
      end
      if (HSEL && HTRANS[1] && HREADY) begin pend = 1'b1; waits = 0; prev_resp = 1'b0; end
    end
  end

  // APB monitor: scores each completed access and checks signals held from SETUP.
  logic [NSLV-1:0]    c_psel;
  logic [PADDR_W-1:0] c_paddr;
  logic               c_pwrite, moved = 1'b0;
  logic [31:0]        c_pwdata;
  always @(negedge HCLK) begin
    apb_exp_t a;
    if (!HRESET && |PSEL) begin
      if (!PENABLE) begin
        setups++;
        c_psel = PSEL; c_paddr = PADDR; c_pwrite = PWRITE; c_pwdata = PWDATA; moved = 1'b0;
      end else begin
        if ({PSEL, PADDR, PWRITE, PWDATA} != {c_psel, c_paddr, c_pwrite, c_pwdata}) moved = 1'b1;
        if (|(PSEL & PREADY)) begin
          if (apb_q.size() == 0) fail("apb_unexpected_access", 32'(PSEL), 0);
          else begin
            a = apb_q.pop_front();
            chk("psel", 32'(PSEL), 32'(a.psel));
            chk("paddr", 32'(PADDR), 32'(a.paddr));
            chk("pwrite", PWRITE, a.pwrite);
            if (a.pwrite) chk("pwdata", PWDATA, a.pwdata);
            chk("apb_stable", moved, 1'b0);
          end
        end
      end
    end
  end

  task automatic exp_ahb(input logic err, input logic rd, input logic [31:0] rdata, input int w);
    ahb_q.push_back('{err, rd, rdata, w});
  endtask

  task automatic exp_apb(input logic [NSLV-1:0] ps, input logic [PADDR_W-1:0] pa, input logic pw, input logic [31:0] pd);
    apb_q.push_back('{ps, pa, pw, pd});
  endtask

  // Presents an address phase, returns #1 after the accepting edge with the data phase driven.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd, output int acc_cyc);
    int n = 0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w;
    @(negedge HCLK);
    while (!HREADYOUT && n < 300) begin @(negedge HCLK); n++; end
    if (n >= 300) fail("accept_timeout", n, 300);
    @(posedge HCLK);
    acc_cyc = cyc;
    #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wd;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ahb_q.size() != 0 || apb_q.size() != 0 || pend) && n < 300) begin @(negedge HCLK); n++; end
    if (n >= 300) fail("idle_timeout", n, 300);
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  task automatic reset_pulse();
    @(posedge HCLK); #1 HRESET = 1'b1;
    @(posedge HCLK); #1;
    chk("rst_psel", 32'(PSEL), 0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_hreadyout", HREADYOUT, 1'b1);
    chk("rst_hrdata", HRDATA, 32'h0);
    HRESET = 1'b0;
    ready_delay = 0;
  endtask

  initial begin
    int c1, c2, s, lows;
    PRDATA[32*0 +: 32] = 32'h0000_AAAA;
    PRDATA[32*1 +: 32] = 32'hCAFE_F00D;
    PRDATA[32*2 +: 32] = 32'h2222_BBBB;
    PRDATA[32*3 +: 32] = 32'h3333_AAAA;
    repeat (3) @(posedge HCLK);
    #1;
    chk("reset_hreadyout", HREADYOUT, 1'b1);
    chk("reset_hresp", HRESP, 1'b0);
    chk("reset_hrdata", HRDATA, 32'h0);
    chk("reset_psel", 32'(PSEL), 0);
    chk("reset_penable", PENABLE, 1'b0);
    chk("reset_pwrite", PWRITE, 1'b0);
    chk("reset_paddr", 32'(PADDR), 0);
    chk("reset_pwdata", PWDATA, 32'h0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // zero-wait read from slave 1
    exp_ahb(1'b0, 1'b1, 32'hCAFE_F00D, 3);
    exp_apb(4'b0010, 16'h0004, 1'b0, 32'h0);
    xfer(32'h6001_0004, 1'b0, 32'h0, c1);
    wait_idle();

    // write to slave 0 with three PREADY-low ACCESS cycles
    ready_delay = 3;
    exp_ahb(1'b0, 1'b0, 32'h0, 6);
    exp_apb(4'b0001, 16'h0010, 1'b1, 32'h1234_5678);
    xfer(32'h6000_0010, 1'b1, 32'h1234_5678, c1);
    wait_idle();
    ready_delay = 0;
    chk("hrdata_kept_after_write", HRDATA, 32'hCAFE_F00D);

    // slave error on slave 2
    err_mask = 4'b0100;
    exp_ahb(1'b1, 1'b1, 32'h0, 4);
    exp_apb(4'b0100, 16'h0008, 1'b0, 32'h0);
    xfer(32'h6002_0008, 1'b0, 32'h0, c1);
    wait_idle();
    err_mask = '0;

    // slave index out of range: error without any APB access
    s = setups;
    exp_ahb(1'b1, 1'b0, 32'h0, 2);
    xfer(32'h6009_0000, 1'b1, 32'hDEAD_BEEF, c1);
    wait_idle();
    chk("bad_idx_no_psel", setups, s);

    // back-to-back reads, second accepted in DONE
    PRDATA[32*1 +: 32] = 32'h1111_5555;
    exp_ahb(1'b0, 1'b1, 32'h3333_AAAA, 3);
    exp_apb(4'b1000, 16'h0020, 1'b0, 32'h0);
    exp_ahb(1'b0, 1'b1, 32'h1111_5555, 3);
    exp_apb(4'b0010, 16'h0040, 1'b0, 32'h0);
    xfer(32'h6003_0020, 1'b0, 32'h0, c1);
    xfer(32'h6001_0040, 1'b0, 32'h0, c2);
    chk("b2b_accept_gap", c2 - c1, 4);
    wait_idle();

    // HSEL with BUSY then IDLE: no transfer
    s = setups;
    HSEL = 1'b1; HTRANS = 2'b01;
    repeat (3) begin
      @(negedge HCLK);
      chk("busy_hreadyout", HREADYOUT, 1'b1);
      chk("busy_hresp", HRESP, 1'b0);
    end
    HTRANS = 2'b00;
    @(negedge HCLK);
    chk("idle_hreadyout", HREADYOUT, 1'b1);
    HSEL = 1'b0;
    chk("busy_no_apb", setups, s);
    @(posedge HCLK); #1;

    // reset during ACCESS drops the transfer
    ready_delay = 1000;
    xfer(32'h6001_0000, 1'b0, 32'h0, c1);
    s = 0;
    while (!PENABLE && s < 50) begin @(negedge HCLK); s++; end
    chk("reached_access", PENABLE, 1'b1);
    reset_pulse();

    // stalled slave
    ready_delay = 1000;
`ifdef AHBL_APB_TIMEOUT_EN
    exp_ahb(1'b1, 1'b0, 32'h0, 11);
    xfer(32'h6000_0000, 1'b0, 32'h0, c1);
    wait_idle();
    ready_delay = 0;
`else
    xfer(32'h6000_0000, 1'b0, 32'h0, c1);
    lows = 0;
    repeat (110) begin
      @(negedge HCLK);
      if (!HREADYOUT) lows++;
    end
    chk("no_timeout_hold", lows, 110);
    reset_pulse();
`endif

    wait_idle();
    chk("ahb_q_drained", ahb_q.size(), 0);
    chk("apb_q_drained", apb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog: got %0d checks expected completion", n_chk);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahbl_apb_bridge.md
# ahbl_apb_bridge

AHB-Lite slave that converts single AHB transfers into APB3 transfers for a bank of up to 16 peripherals. It sits directly downstream of the AHB splitter on the peripheral page. The splitter drives HSEL and consumes HRDATA/HREADYOUT/HRESP. The bridge holds the AHB data phase with wait states until the APB access completes, then returns read data or an error response.

## Interface
- `NSLV`, default 4: number of APB slaves, range 1–16.
- `PADDR_W`, default 16: APB address width; each slave owns a 2^PADDR_W byte window.
- `TIMEOUT_CYC`, default 255: maximum ACCESS cycles before abort. Used only when the timeout feature is compiled in.

Ports:
- `HCLK` in 1: single clock for AHB and APB sides.
- `HRESET` in 1: reset, synchronous, active-high.
- `HSEL` in 1: slave select from the splitter.
- `HADDR` in 32: AHB address.
- `HTRANS` in 2: transfer type; bit 1 set means NONSEQ/SEQ.
- `HWRITE` in 1: write when 1.
- `HWDATA` in 32: write data, valid in the data phase.
- `HREADY` in 1: bus-level ready.
- `HREADYOUT` out 1: this slave's ready.
- `HRDATA` out 32: read data.
- `HRESP` out 1: 0 = OKAY, 1 = ERROR.
- `PADDR` out PADDR_W: APB address, taken from HADDR[PADDR_W-1:0].
- `PSEL` out NSLV: one-hot APB select.
- `PENABLE` out 1: APB enable.
- `PWRITE` out 1: APB direction.
- `PWDATA` out 32: APB write data.
- `PRDATA` in 32*NSLV: per-slave read data; slave i occupies bits [32i+31:32i].
- `PREADY` in NSLV: per-slave ready.
- `PSLVERR` in NSLV: per-slave error.

## Operation
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled on a rising HCLK edge. On accept, latch HADDR, HWRITE and slave index `idx` = HADDR[PADDR_W+3:PADDR_W].
- HSEL with IDLE or BUSY HTRANS: no action; HREADYOUT stays 1 and HRESP stays 0.
- FSM states and transitions:
  - IDLE: on accept → CAPTURE.
  - CAPTURE: latch HWDATA into PWDATA (writes only). If idx >= NSLV → ERR1, else → SETUP.
  - SETUP: PSEL[idx]=1, PENABLE=0 → ACCESS.
  - ACCESS: PSEL[idx]=1, PENABLE=1. Stay while PREADY[idx]=0. When PREADY[idx]=1: if PSLVERR[idx]=1 → ERR1, else register PRDATA slice into HRDATA (reads only) → DONE.
  - DONE: HREADYOUT=1, HRESP=0. On accept → CAPTURE, else → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. On accept → CAPTURE, else → IDLE.
- HREADYOUT=0 in CAPTURE, SETUP, ACCESS and ERR1; HREADYOUT=1 in IDLE, DONE and ERR2.
- PSEL and PENABLE are 0 in every state other than SETUP and ACCESS.
- PADDR, PWRITE and PWDATA hold stable from SETUP through the final ACCESS cycle.
- HRDATA holds its last value until the next completed read; it is not cleared on writes.
- Reset mid-transfer: all state and outputs return to reset values at the next edge. The APB transfer is dropped without completion.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0. FSM starts in IDLE.
- Zero-wait APB slave, address phase in cycle 0: CAPTURE in cycle 1, SETUP in cycle 2, ACCESS in cycle 3, DONE in cycle 4. This gives 3 AHB wait states; each extra PREADY-low cycle adds one.
- Back-to-back transfers: an accept in DONE or ERR2 enters CAPTURE on the next cycle, with no idle gap.
- Error response is always two cycles (ERR1 then ERR2), as AHB-Lite requires.

## Configuration
- Macro `AHBL_APB_TIMEOUT_EN`.
- Defined: an 8–16 bit counter runs in ACCESS. If it reaches TIMEOUT_CYC with PREADY[idx] still 0, PSEL and PENABLE drop and the FSM goes to ERR1.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

## Structure
- Package `ahbl_apb_pkg` holds:
  - FSM state encoding (IDLE, CAPTURE, SETUP, ACCESS, DONE, ERR1, ERR2).
  - HTRANS encodings (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11).
  - HRESP codes.
- Sub-module `apb_slave_mux`: selects PRDATA, PREADY and PSLVERR by idx. Purely combinational; instantiated once.

## Test plan
- Read from slave 1, HADDR=0x6001_0004, PRDATA1=0xCAFE_F00D, PREADY tied high → PADDR=0x0004, PSEL=4'b0010; HRDATA=0xCAFE_F00D with HREADYOUT=1 in cycle 4, HRESP=0.
- Write 0x1234_5678 to slave 0, PREADY low for 3 ACCESS cycles → PWDATA=0x1234_5678 stable throughout, PWRITE=1, HREADYOUT rises in cycle 7.
- PSLVERR=1 with PREADY=1 on slave 2 → HRESP=1 for two cycles, HREADYOUT pattern 0 then 1.
- Slave index 9 with NSLV=4 → no PSEL activity; two-cycle ERROR response starting in cycle 2.
- Two back-to-back NONSEQ reads (second accepted in DONE) → second SETUP in cycle 6. Then HRESET pulse during ACCESS → PSEL=0, PENABLE=0, HREADYOUT=1 on the next edge.
- With `AHBL_APB_TIMEOUT_EN` defined and TIMEOUT_CYC=8, PREADY held low → abort after 8 ACCESS cycles, ERROR response. Without the macro, the bench observes HREADYOUT=0 for 100 or more cycles.
